// File: rtl/sensor_pattern_gen_if.sv
// sensor_pattern_gen_if
//   Bundles the request handshake and the photocell/status outputs of
//   sensor_pattern_gen.
//   Signals:
//     req_valid    request present (master -> slave)
//     req_dir      1 = enter, 0 = exit (master -> slave)
//     req_ready    queue can accept a request (slave -> master)
//     wej, wyj     entry / exit photocell lines, 1 = beam clear
//     busy         queue non-empty or generator not idle
//     expected_cnt net generated occupancy, modulo 2^CW
interface sensor_pattern_gen_if #(
    parameter int CW = 8
) ();
    logic          req_valid;
    logic          req_dir;
    logic          req_ready;
    logic          wej;
    logic          wyj;
    logic          busy;
    logic [CW-1:0] expected_cnt;

    modport master (
        output req_valid, req_dir,
        input  req_ready, wej, wyj, busy, expected_cnt
    );

    modport slave (
        input  req_valid, req_dir,
        output req_ready, wej, wyj, busy, expected_cnt
    );
endinterface

// File: rtl/sensor_pattern_gen.sv
// sensor_pattern_gen
//   Turns queued enter/exit requests into timed wej/wyj photocell waveforms
//   (idle 11, enter 01, exit 10) and tracks the net occupancy it generated.
//   Ports:
//     clk  clock, all logic on the rising edge
//     rst  synchronous active-high reset
//     bus  sensor_pattern_gen_if.slave: req_valid/req_dir/req_ready handshake,
//          registered wej/wyj/expected_cnt, combinational busy
module sensor_pattern_gen #(
    parameter int HOLD  = 4,
    parameter int GAP   = 2,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sensor_pattern_gen_if.slave  bus
);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    // Request queue
    logic          r_q [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // FSM and registered outputs
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_wej;
    logic          r_wyj;
    logic          r_dir;
    logic [HW-1:0] r_hold;
    logic [GW-1:0] r_gap;
    logic [CW-1:0] r_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_head;
    logic          w_wej_nxt;
    logic          w_wyj_nxt;
    logic          w_dir_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // Ready depends only on fullness, never on a same-cycle pop.
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.req_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_head  = r_q[r_rd_ptr];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (r_hold == '0) w_state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:    if (r_gap == '0) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered lines, timers and counter
    always_comb begin
        w_wej_nxt  = 1'b1;
        w_wyj_nxt  = 1'b1;
        w_dir_nxt  = r_dir;
        w_hold_nxt = r_hold;
        w_gap_nxt  = r_gap;
        w_cnt_nxt  = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    // enter drives 01, exit drives 10; never 00
                    w_wej_nxt  = !w_head;
                    w_wyj_nxt  = w_head;
                    w_dir_nxt  = w_head;
                    w_hold_nxt = HW'(HOLD - 1);
                end
            end
            S_ACTIVE: begin
                if (r_hold == '0) begin
                    w_cnt_nxt = r_dir ? r_cnt + CW'(1) : r_cnt - CW'(1);
                    w_gap_nxt = GW'(GAP_LD);
                end else begin
                    w_wej_nxt  = r_wej;
                    w_wyj_nxt  = r_wyj;
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            S_GAP: begin
                if (r_gap != '0) w_gap_nxt = r_gap - GW'(1);
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wej    <= 1'b1;
            r_wyj    <= 1'b1;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wej <= w_wej_nxt;
            r_wyj <= w_wyj_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage and timers only matter while qualified by state/count
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wr_ptr] <= bus.req_dir;
        r_dir  <= w_dir_nxt;
        r_hold <= w_hold_nxt;
        r_gap  <= w_gap_nxt;
    end

    assign bus.req_ready    = !w_full;
    assign bus.busy         = !w_empty || (r_state != S_IDLE);
    assign bus.wej          = r_wej;
    assign bus.wyj          = r_wyj;
    assign bus.expected_cnt = r_cnt;
endmodule

// File: tb/tb_sensor_pattern_gen.sv
// tb_sensor_pattern_gen
//   Directed bench for sensor_pattern_gen: dut0 uses HOLD=4/GAP=2/DEPTH=4,
//   dut1 uses HOLD=1/GAP=0. A line monitor on dut0 records pattern order,
//   hold and idle run lengths and a decoded occupancy count.
module tb_sensor_pattern_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sensor_pattern_gen_if #(.CW(8)) b0 ();
    sensor_pattern_gen_if #(.CW(8)) b1 ();

    sensor_pattern_gen #(.HOLD(4), .GAP(2), .DEPTH(4), .CW(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    sensor_pattern_gen #(.HOLD(1), .GAP(0), .DEPTH(4), .CW(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    // Line monitor (dut0), sampled on the falling edge
    logic       mon_clr = 1'b0;
    logic       saw00   = 1'b0;
    logic [1:0] prev    = 2'b11;
    int         idle_run = 0;
    int         act_run  = 0;
    logic [7:0] lb_cnt   = 8'd0;
    int         dir_q[$];
    int         gap_q[$];
    int         hold_q[$];

    always @(negedge clk) begin
        logic [1:0] cur;
        cur = {b0.wej, b0.wyj};
        if (cur == 2'b00 || {b1.wej, b1.wyj} == 2'b00) saw00 = 1'b1;
        if (mon_clr) begin
            dir_q.delete();
            gap_q.delete();
            hold_q.delete();
            prev     = 2'b11;
            idle_run = 0;
            act_run  = 0;
            lb_cnt   = 8'd0;
        end else begin
            if (cur == 2'b11) begin
                if (prev != 2'b11) begin
                    hold_q.push_back(act_run);
                    lb_cnt   = (prev == 2'b01) ? lb_cnt + 8'd1 : lb_cnt - 8'd1;
                    idle_run = 1;
                end else begin
                    idle_run++;
                end
            end else begin
                if (prev == 2'b11) begin
                    gap_q.push_back(idle_run);
                    dir_q.push_back((cur == 2'b01) ? 1 : 0);
                    act_run = 1;
                end else begin
                    act_run++;
                end
            end
            prev = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_req(input logic d);
        int t;
        t = 0;
        b0.req_valid = 1'b1;
        b0.req_dir   = d;
        while (!b0.req_ready && t < 1000) begin
            tick();
            t++;
        end
        if (t >= 1000) check("push_timeout", 32'(t), 32'd0);
        tick();
        b0.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (b0.busy && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) check("idle_timeout", 32'(t), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    initial begin
        int   i;
        int   t;
        logic acc;
        int   dirs[5];
        dirs = '{1, 1, 0, 1, 0};
        b0.req_valid = 1'b0;
        b0.req_dir   = 1'b0;
        b1.req_valid = 1'b0;
        b1.req_dir   = 1'b0;
        tick();
        do_reset();

        // Reset state
        check("rst_lines", 32'({b0.wej, b0.wyj}), 32'd3);
        check("rst_cnt", 32'(b0.expected_cnt), 32'd0);
        check("rst_ready", 32'(b0.req_ready), 32'd1);
        check("rst_busy", 32'(b0.busy), 32'd0);

        // Reset mid-ENTER with a second request queued
        push_req(1'b1);
        b0.req_valid = 1'b1;
        b0.req_dir   = 1'b1;
        tick();
        b0.req_valid = 1'b0;
        check("mid_lines", 32'({b0.wej, b0.wyj}), 32'd1);
        check("mid_busy", 32'(b0.busy), 32'd1);
        do_reset();
        check("abort_lines", 32'({b0.wej, b0.wyj}), 32'd3);
        check("abort_cnt", 32'(b0.expected_cnt), 32'd0);
        check("abort_ready", 32'(b0.req_ready), 32'd1);
        check("abort_busy", 32'(b0.busy), 32'd0);
        tick();
        tick();
        check("flushed_lines", 32'({b0.wej, b0.wyj}), 32'd3);
        check("flushed_busy", 32'(b0.busy), 32'd0);

        // Single ENTER, edge-by-edge
        clear_mon();
        push_req(1'b1);
        check("se_e0_lines", 32'({b0.wej, b0.wyj}), 32'd3);
        check("se_e0_busy", 32'(b0.busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("se_e%0d_lines", k), 32'({b0.wej, b0.wyj}), 32'd1);
        end
        check("se_e4_cnt", 32'(b0.expected_cnt), 32'd0);
        tick();
        check("se_e5_lines", 32'({b0.wej, b0.wyj}), 32'd3);
        check("se_e5_cnt", 32'(b0.expected_cnt), 32'd1);
        tick();
        check("se_e6_busy", 32'(b0.busy), 32'd1);
        tick();
        tick();
        check("se_e8_busy", 32'(b0.busy), 32'd0);

        // Burst E,E,X,E,X
        do_reset();
        clear_mon();
        i = 0;
        t = 0;
        while (i < 5 && t < 100) begin
            b0.req_valid = 1'b1;
            b0.req_dir   = dirs[i][0];
            acc = b0.req_ready;
            tick();
            if (acc) i++;
            t++;
        end
        b0.req_valid = 1'b0;
        check("burst_accepted", 32'(i), 32'd5);
        check("burst_full_ready", 32'(b0.req_ready), 32'd0);
        wait_idle();
        check("burst_events", 32'(dir_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("burst_dir%0d", k), 32'(dir_q[k]), 32'(dirs[k]));
            check($sformatf("burst_hold%0d", k), 32'(hold_q[k]), 32'd4);
            if (k > 0) check($sformatf("burst_gap%0d", k), 32'(gap_q[k]), 32'd3);
        end
        check("burst_cnt", 32'(b0.expected_cnt), 32'd1);

        // Wrap
        do_reset();
        for (int k = 0; k < 255; k++) push_req(1'b1);
        wait_idle();
        check("wrap_255", 32'(b0.expected_cnt), 32'd255);
        push_req(1'b1);
        wait_idle();
        check("wrap_0", 32'(b0.expected_cnt), 32'd0);
        push_req(1'b0);
        wait_idle();
        check("wrap_back_255", 32'(b0.expected_cnt), 32'd255);

        // Loopback: decoded line count vs expected_cnt
        do_reset();
        clear_mon();
        for (int k = 0; k < 10; k++) push_req(1'b1);
        for (int k = 0; k < 3; k++) push_req(1'b0);
        wait_idle();
        check("lb_cnt", 32'(b0.expected_cnt), 32'd7);
        check("lb_decoded", 32'(lb_cnt), 32'd7);

        // HOLD=1, GAP=0 instance
        b1.req_valid = 1'b1;
        b1.req_dir   = 1'b1;
        tick();
        tick();
        b1.req_valid = 1'b0;
        check("g0_e1_lines", 32'({b1.wej, b1.wyj}), 32'd1);
        tick();
        check("g0_e2_lines", 32'({b1.wej, b1.wyj}), 32'd3);
        check("g0_e2_cnt", 32'(b1.expected_cnt), 32'd1);
        tick();
        check("g0_e3_lines", 32'({b1.wej, b1.wyj}), 32'd1);
        tick();
        check("g0_e4_lines", 32'({b1.wej, b1.wyj}), 32'd3);
        check("g0_e4_cnt", 32'(b1.expected_cnt), 32'd2);
        check("g0_e4_busy", 32'(b1.busy), 32'd0);

        check("never_00", 32'(saw00), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
